// File: rtl/bit_wise_pkg.sv
// bit_wise_pkg: shared definitions for the bit_wise parity/all-ones stage.
//   BIT_WISE_DEF_WIDTH - default input word width
//   bit_wise_cnt_width - width needed to hold a set-bit count of a WIDTH-bit word
//   bit_wise_res_t     - packed {even, odd, all_one} result bundle
package bit_wise_pkg;

  localparam int unsigned BIT_WISE_DEF_WIDTH = 8;

  // Bits needed to represent 0..width inclusive.
  function automatic int unsigned bit_wise_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  typedef struct packed {
    logic even;
    logic odd;
    logic all_one;
  } bit_wise_res_t;

  // Result for an all-zero word; also the reset value of the output flags.
  localparam bit_wise_res_t BIT_WISE_RES_ZERO = '{even: 1'b1, odd: 1'b0, all_one: 1'b0};

endpackage

// File: rtl/bit_wise_reduce.sv
// bit_wise_reduce: purely combinational reduction of one word.
//   word      (in)  WIDTH-bit word to evaluate
//   res       (out) {even, odd, all_one} flags for word
//   pop_count (out) number of set bits in word; present only with BIT_WISE_POPCOUNT_EN
module bit_wise_reduce
  import bit_wise_pkg::*;
#(
  parameter int unsigned WIDTH = BIT_WISE_DEF_WIDTH
) (
  input  logic [WIDTH-1:0]                        word,
`ifdef BIT_WISE_POPCOUNT_EN
  output logic [bit_wise_cnt_width(WIDTH)-1:0]    pop_count,
`endif
  output bit_wise_res_t                           res
);

  always_comb begin
    res         = BIT_WISE_RES_ZERO;
    res.odd     = ^word;
    res.even    = ~res.odd;
    res.all_one = &word;
  end

`ifdef BIT_WISE_POPCOUNT_EN
  localparam int unsigned CntW = bit_wise_cnt_width(WIDTH);

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop_count = pop_count + {{(CntW-1){1'b0}}, word[i]};
    end
  end
`endif

endmodule

// File: rtl/bit_wise.sv
// bit_wise: registered parity / all-ones status stage.
// Optional feature macro: BIT_WISE_POPCOUNT_EN adds the registered pop_count output.
//   clk       (in)  rising-edge clock
//   rst_n     (in)  synchronous active-low reset
//   in_valid  (in)  sample input_bus this cycle
//   input_bus (in)  WIDTH-bit word
//   out_valid (out) one-cycle pulse, one cycle after each accepted word
//   even      (out) captured word has an even number of set bits
//   odd       (out) captured word has an odd number of set bits (~even)
//   all_one   (out) captured word is all ones
//   pop_count (out) set-bit count of captured word (BIT_WISE_POPCOUNT_EN only)
// Flags hold their last value while in_valid is low.
module bit_wise
  import bit_wise_pkg::*;
#(
  parameter int unsigned WIDTH = BIT_WISE_DEF_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [WIDTH-1:0]                     input_bus,
  output logic                                 out_valid,
  output logic                                 even,
  output logic                                 odd,
`ifdef BIT_WISE_POPCOUNT_EN
  output logic [bit_wise_cnt_width(WIDTH)-1:0] pop_count,
`endif
  output logic                                 all_one
);

  bit_wise_res_t res_comb;
  bit_wise_res_t res_d, res_q;
  logic          valid_d, valid_q;

`ifdef BIT_WISE_POPCOUNT_EN
  localparam int unsigned CntW = bit_wise_cnt_width(WIDTH);
  logic [CntW-1:0] cnt_comb, cnt_d, cnt_q;
`endif

  bit_wise_reduce #(
    .WIDTH (WIDTH)
  ) u_reduce (
    .word      (input_bus),
`ifdef BIT_WISE_POPCOUNT_EN
    .pop_count (cnt_comb),
`endif
    .res       (res_comb)
  );

  // Capture only on accepted words; otherwise hold so X on an idle bus cannot leak.
  always_comb begin
    valid_d = in_valid;
    res_d   = res_q;
    if (in_valid) begin
      res_d = res_comb;
    end
  end

`ifdef BIT_WISE_POPCOUNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = cnt_comb;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= BIT_WISE_RES_ZERO;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

`ifdef BIT_WISE_POPCOUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pop_count = cnt_q;
`endif

  assign out_valid = valid_q;
  assign even      = res_q.even;
  assign odd       = res_q.odd;
  assign all_one   = res_q.all_one;

endmodule

// File: tb/tb_bit_wise.sv
module tb_bit_wise;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] input_bus;
  logic         out_valid;
  logic         even;
  logic         odd;
  logic         all_one;
`ifdef BIT_WISE_POPCOUNT_EN
  logic [$clog2(W+1)-1:0] pop_count;
`endif

  bit_wise #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .input_bus (input_bus),
    .out_valid (out_valid),
    .even      (even),
    .odd       (odd),
`ifdef BIT_WISE_POPCOUNT_EN
    .pop_count (pop_count),
`endif
    .all_one   (all_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should show after the latest edge.
  logic m_valid;
  int   m_cnt;

  function automatic int count_ones(input logic [W-1:0] v);
    int n;
    longint unsigned x;
    n = 0;
    x = longint'(v);
    while (x != 0) begin
      n = n + int'(x % 2);
      x = x / 2;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".even"},      32'(even),      32'(m_cnt % 2 == 0));
    chk({tag, ".odd"},       32'(odd),       32'(m_cnt % 2 == 1));
    chk({tag, ".all_one"},   32'(all_one),   32'(m_cnt == int'(W)));
    chk({tag, ".even_ne_odd"}, 32'(even != odd), 32'd1);
`ifdef BIT_WISE_POPCOUNT_EN
    chk({tag, ".pop_count"}, 32'(pop_count), 32'(m_cnt));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
  task automatic cycle(input logic rst, input logic v, input logic [W-1:0] d, input string tag);
    @(negedge clk);
    rst_n     = rst;
    in_valid  = v;
    input_bus = d;
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b0;
      m_cnt   = 0;
    end else begin
      m_valid = v;
      if (v) m_cnt = count_ones(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         v;
    logic         r;
    m_valid   = 1'b0;
    m_cnt     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    input_bus = '0;

    cycle(1'b0, 1'b0, 8'h00, "reset0");
    cycle(1'b0, 1'b0, 8'h00, "reset1");

    // Single words with idle gaps.
    cycle(1'b1, 1'b1, 8'h00, "w00");
    cycle(1'b1, 1'b0, 8'h00, "idle_a");
    cycle(1'b1, 1'b1, 8'hFF, "wFF");
    cycle(1'b1, 1'b0, 8'h00, "hold_FF");
    cycle(1'b1, 1'b1, 8'h92, "w92");
    cycle(1'b1, 1'b0, 8'h00, "hold_92");
    cycle(1'b1, 1'b1, 8'h96, "w96");
    cycle(1'b1, 1'b0, 8'h00, "hold_96");

    // Back-to-back stream then idle with garbage on the bus.
    cycle(1'b1, 1'b1, 8'h00, "bb00");
    cycle(1'b1, 1'b1, 8'hFF, "bbFF");
    cycle(1'b1, 1'b1, 8'h92, "bb92");
    cycle(1'b1, 1'b1, 8'h96, "bb96");
    cycle(1'b1, 1'b0, 8'hFF, "bb_hold0");
    cycle(1'b1, 1'b0, 8'h01, "bb_hold1");

    // Reset with a simultaneous valid word: word dropped.
    cycle(1'b1, 1'b1, 8'hFF, "pre_rst");
    cycle(1'b0, 1'b1, 8'h92, "rst_drop");
    cycle(1'b1, 1'b1, 8'h7F, "w7F");
    cycle(1'b1, 1'b0, 8'h00, "hold_7F");

    // Randomized traffic with occasional reset and biased corner words.
    for (int i = 0; i < 300; i++) begin
      d = W'($urandom);
      case ($urandom_range(0, 7))
        0: d = '1;
        1: d = '0;
        default: ;
      endcase
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 39) != 0);
      cycle(r, v, d, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_wise.md
Name: bit_wise

Overview:
- Registered bit-reduction block that flags the parity and the all-ones condition of a parallel input bus.
- Samples `input_bus` every cycle in which `in_valid` is high.
- Outputs are an even-parity flag, an odd-parity flag and an all-ones flag, valid one cycle later.
- Used as a status/check stage on data words wherever a parity or saturation indication is needed.

Parameters:
- WIDTH, 8, bit width of `input_bus`; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  `input_bus` is sampled this cycle when high.
- input_bus  input  WIDTH  word to be evaluated.
- out_valid  output  1  high for exactly one cycle per accepted word, one cycle after acceptance.
- even  output  1  1 when the number of set bits in the captured word is even (zero counts as even).
- odd  output  1  1 when the number of set bits is odd; always the complement of `even`.
- all_one  output  1  1 when every bit of the captured word is 1.

Behaviour:
- Reset (rst_n low at a clock edge):
  - out_valid=0, even=1, odd=0, all_one=0, i.e. the result for an all-zero word.
  - Reset wins over a simultaneous in_valid; that word is dropped.
- Normal cycle, in_valid=1 at edge N:
  - even, odd and all_one at edge N+1 reflect input_bus sampled at N.
  - out_valid=1 from edge N+1 until edge N+2.
  - Fixed latency of 1 cycle.
  - Back-to-back acceptance every cycle is supported; there is no backpressure and no ready signal.
- in_valid=0 at edge N:
  - out_valid=0 at N+1.
  - even, odd and all_one hold their last values.
- Output relations:
  - odd = XOR reduction of all bits.
  - even = ~odd.
  - all_one = AND reduction of all bits.
  - even and odd are never equal, including in reset.
- Output glitches: outputs come directly from flops, so no combinational path from inputs to outputs.
- X on input_bus while in_valid=0: no effect on outputs.
- Reset released mid-stream: the first accepted word after rst_n returns high is processed normally; there is no warm-up cycle.

Optional Feature:
- Macro: BIT_WISE_POPCOUNT_EN.
- When defined:
  - Adds output `pop_count`, width $clog2(WIDTH+1), holding the number of set bits in the captured word.
  - It is registered alongside the flags with the same timing and hold behaviour.
  - Resets to 0.
  - pop_count[0] must equal odd, and all_one must equal (pop_count == WIDTH).
- When not defined:
  - The port and its counting logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package bit_wise_pkg:
  - BIT_WISE_DEF_WIDTH=8.
  - Localparam/function for the count width, clog2(WIDTH+1).
  - A result struct typedef {even, odd, all_one}.
- One combinational sub-module bit_wise_reduce:
  - Parameterised by WIDTH.
  - Produces the parity, all-ones and (optional) popcount results from a word.
- bit_wise wraps bit_wise_reduce with the valid/output registers.

Test Plan:
- Reset, then one cycle with in_valid=1 and input_bus=8'h00:
  - During reset: even=1, odd=0, all_one=0, out_valid=0.
  - After the 8'h00 word: even=1, odd=0, all_one=0 one cycle later.
  - pop_count=0 when BIT_WISE_POPCOUNT_EN is defined.
- input_bus=8'hFF with in_valid=1:
  - Next cycle: even=1, odd=0, all_one=1, out_valid=1; pop_count=8.
- input_bus=8'h92 (bits 1, 4, 7 set):
  - Next cycle: even=0, odd=1, all_one=0; pop_count=3.
- input_bus=8'h96 (bits 1, 2, 4, 7 set):
  - Next cycle: even=1, odd=0, all_one=0; pop_count=4.
- Back-to-back stream 8'h00, 8'hFF, 8'h92, 8'h96, one word per cycle, then in_valid=0:
  - Results appear on consecutive cycles with out_valid high throughout.
  - The final result (even=1, odd=0, all_one=0) holds with out_valid=0.
- Assert rst_n=0 together with in_valid=1 and input_bus=8'h92:
  - Next cycle shows the reset values with out_valid=0; the word is dropped.
  - After release, 8'h7F gives odd=1, all_one=0 one cycle later.
